sparse_coo_loader: RTL and testbench

- Upstream stage of the outer-product multiplier.
- Accepts a stream of sparse COO entries (matrix select, row, col, value) and expands them into dense NxN operand matrices A and B. Unwritten positions are zero.
- Presents both matrices together with a valid/ready handshake.
- Replaces sequential BRAM fetching of every dense element with transfer of nonzeros only.

---
 rtl/sparse_mm_pkg.sv | 24 ++
 rtl/coo_dense_bank.sv | 58 +++++
 rtl/sparse_coo_loader.sv | 108 ++++++++++
 tb/tb_sparse_coo_loader.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sparse_mm_pkg.sv
// Shared definitions for the sparse outer-product datapath: default sizes,
// loader FSM states, matrix-select codes and the flat-matrix element offset.
package sparse_mm_pkg;

    localparam int N     = 3;
    localparam int W     = 8;
    localparam int IDX_W = 2;
    localparam int CNT_W = 4;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic [1:0] {
        CLEAR,
        LOAD,
        DONE
    } loader_state_t;

    // LSB of element [i][j] in a row-major flat NxN matrix of W-bit elements.
    function automatic int unsigned elem_lsb(input int unsigned i, input int unsigned j);
        return (i * N + j) * W;
    endfunction

endpackage

// File: rtl/coo_dense_bank.sv
// One dense NxN matrix register bank filled from COO writes, with nonzero counter.
// SPARSE_COO_ACCUM_EN: writes accumulate with W-bit saturation instead of overwriting.
module coo_dense_bank #(
    parameter int N     = sparse_mm_pkg::N,
    parameter int W     = sparse_mm_pkg::W,
    parameter int IDX_W = sparse_mm_pkg::IDX_W,
    parameter int CNT_W = sparse_mm_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               wr_en,
    input  logic [IDX_W-1:0]   row,
    input  logic [IDX_W-1:0]   col,
    input  logic [W-1:0]       val,
    output logic [N*N*W-1:0]   mat,
    output logic [CNT_W-1:0]   nnz
);

    localparam int unsigned DEPTH = N * N;
    localparam int          AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] addr;
    logic [W-1:0]  wdata;

    // Caller guarantees row < N and col < N whenever wr_en is high.
    assign addr = AW'(int'(row) * N + int'(col));

`ifdef SPARSE_COO_ACCUM_EN
    logic [W:0] sum;
    assign sum   = {1'b0, mem[addr]} + {1'b0, val};
    assign wdata = sum[W] ? '1 : sum[W-1:0];
`else
    assign wdata = val;
`endif

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
            nnz <= '0;
        end else if (wr_en) begin
            mem[addr] <= wdata;
            if (nnz != '1) begin
                nnz <= nnz + 1'b1;
            end
        end
    end

    always_comb begin
        mat = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            mat[k*W +: W] = mem[k];
        end
    end

endmodule

// File: rtl/sparse_coo_loader.sv
// Expands a shared COO entry stream into dense A/B operand matrices and hands
// them downstream with valid/ready. SPARSE_COO_ACCUM_EN selects accumulate writes.
module sparse_coo_loader #(
    parameter int N     = sparse_mm_pkg::N,
    parameter int W     = sparse_mm_pkg::W,
    parameter int IDX_W = sparse_mm_pkg::IDX_W,
    parameter int CNT_W = sparse_mm_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic               s_sel,
    input  logic [IDX_W-1:0]   s_row,
    input  logic [IDX_W-1:0]   s_col,
    input  logic [W-1:0]       s_val,
    input  logic               s_last,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [N*N*W-1:0]   m_a,
    output logic [N*N*W-1:0]   m_b,
    output logic [CNT_W-1:0]   nnz_a,
    output logic [CNT_W-1:0]   nnz_b,
    output logic               idx_err
);

    import sparse_mm_pkg::*;

    loader_state_t state, state_next;

    logic accept;
    logic in_range;
    logic done_hs;
    logic clear;
    logic wr_a;
    logic wr_b;

    // Handshake outputs decode the state register directly, so both are registered.
    assign s_ready  = (state == LOAD);
    assign m_valid  = (state == DONE);
    assign accept   = s_valid && s_ready;
    assign done_hs  = m_valid && m_ready;
    assign in_range = ({1'b0, s_row} < (IDX_W+1)'(N)) && ({1'b0, s_col} < (IDX_W+1)'(N));

    // Zeroing happens on the edge that enters CLEAR, so outputs already read zero in CLEAR.
    assign clear = rst || done_hs || (state == CLEAR);
    assign wr_a  = accept && in_range && (s_sel == SEL_A);
    assign wr_b  = accept && in_range && (s_sel == SEL_B);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            CLEAR: state_next = LOAD;
            LOAD:  if (accept && s_last) state_next = DONE;
            DONE:  if (done_hs) state_next = CLEAR;
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            idx_err <= 1'b0;
        end else if (accept && !in_range) begin
            idx_err <= 1'b1;
        end
    end

    coo_dense_bank #(
        .N     (N),
        .W     (W),
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) bank_a (
        .clk   (clk),
        .clear (clear),
        .wr_en (wr_a),
        .row   (s_row),
        .col   (s_col),
        .val   (s_val),
        .mat   (m_a),
        .nnz   (nnz_a)
    );

    coo_dense_bank #(
        .N     (N),
        .W     (W),
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) bank_b (
        .clk   (clk),
        .clear (clear),
        .wr_en (wr_b),
        .row   (s_row),
        .col   (s_col),
        .val   (s_val),
        .mat   (m_b),
        .nnz   (nnz_b)
    );

endmodule

// File: tb/tb_sparse_coo_loader.sv
// Self-checking bench for sparse_coo_loader: directed COO streams against a
// behavioural matrix model, plus literal expectations per scenario.
module tb_sparse_coo_loader;

    import sparse_mm_pkg::*;

    localparam int MW = N * N * W;

    logic              clk;
    logic              rst;
    logic              s_valid;
    logic              s_ready;
    logic              s_sel;
    logic [IDX_W-1:0]  s_row;
    logic [IDX_W-1:0]  s_col;
    logic [W-1:0]      s_val;
    logic              s_last;
    logic              m_valid;
    logic              m_ready;
    logic [MW-1:0]     m_a;
    logic [MW-1:0]     m_b;
    logic [CNT_W-1:0]  nnz_a;
    logic [CNT_W-1:0]  nnz_b;
    logic              idx_err;

    int checks = 0;
    int errors = 0;

    // Behavioural model: dense matrices, counters, error flag, expected handshake levels.
    int ma [N][N];
    int mb [N][N];
    int na, nb;
    bit merr;
    bit mclr = 1'b1;
    bit mrdy = 1'b0;
    bit mvld = 1'b0;

    int ta [N][N];
    int tbm [N][N];

    sparse_coo_loader #(
        .N     (N),
        .W     (W),
        .IDX_W (IDX_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_sel   (s_sel),
        .s_row   (s_row),
        .s_col   (s_col),
        .s_val   (s_val),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_a     (m_a),
        .m_b     (m_b),
        .nnz_a   (nnz_a),
        .nnz_b   (nnz_b),
        .idx_err (idx_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [MW-1:0] pack(input int m [N][N]);
        logic [MW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                v[elem_lsb(i, j) +: W] = W'(m[i][j]);
        return v;
    endfunction

    function automatic logic [W-1:0] el(input logic [MW-1:0] m, input int i, input int j);
        return m[elem_lsb(i, j) +: W];
    endfunction

    task automatic model_zero();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ma[i][j] = 0;
                mb[i][j] = 0;
            end
        na = 0;
        nb = 0;
        merr = 1'b0;
    endtask

    function automatic int wr_elem(input int old, input int v);
`ifdef SPARSE_COO_ACCUM_EN
        return (old + v > 255) ? 255 : old + v;
`else
        return v + 0 * old;
`endif
    endfunction

    // Model advance on each rising edge, from the stimulus and its own expectations only.
    always @(posedge clk) begin
        if (rst) begin
            model_zero();
            mclr = 1'b1;
            mrdy = 1'b0;
            mvld = 1'b0;
        end else if (mclr) begin
            mclr = 1'b0;
            mrdy = 1'b1;
        end else if (mrdy) begin
            if (s_valid) begin
                if (int'(s_row) < N && int'(s_col) < N) begin
                    if (s_sel) begin
                        mb[s_row][s_col] = wr_elem(mb[s_row][s_col], int'(s_val));
                        nb = (nb == 15) ? 15 : nb + 1;
                    end else begin
                        ma[s_row][s_col] = wr_elem(ma[s_row][s_col], int'(s_val));
                        na = (na == 15) ? 15 : na + 1;
                    end
                end else begin
                    merr = 1'b1;
                end
                if (s_last) begin
                    mrdy = 1'b0;
                    mvld = 1'b1;
                end
            end
        end else if (mvld && m_ready) begin
            mvld = 1'b0;
            mclr = 1'b1;
            model_zero();
        end
    end

    always @(negedge clk) begin
        chk("s_ready", s_ready, mrdy);
        chk("m_valid", m_valid, mvld);
        chk("m_a", m_a, pack(ma));
        chk("m_b", m_b, pack(mb));
        chk("nnz_a", nnz_a, MW'(na));
        chk("nnz_b", nnz_b, MW'(nb));
        chk("idx_err", idx_err, merr);
    end

    task automatic send(input logic sel, input int r, input int c, input int v, input logic last);
        int n;
        n = 0;
        s_valid = 1'b1;
        s_sel   = sel;
        s_row   = IDX_W'(r);
        s_col   = IDX_W'(c);
        s_val   = W'(v);
        s_last  = last;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout actual=no_ready required=ready at %0t", $time);
        end else begin
            @(negedge clk);
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic release_pair();
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    initial begin
        logic [MW-1:0] ev;
        int pe, pa;

        rst = 1'b1;
        s_valid = 1'b0; s_sel = 1'b0; s_row = '0; s_col = '0; s_val = '0; s_last = 1'b0;
        m_ready = 1'b0;
        idle(3);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_a", m_a, 0);
        chk("rst_nnz_b", nnz_b, 0);
        chk("rst_idx_err", idx_err, 0);
        rst = 1'b0;

        // Basic pair and latency of m_valid after the last entry.
        send(SEL_A, 0, 0, 5, 1'b0);
        send(SEL_A, 2, 1, 7, 1'b0);
        send(SEL_B, 1, 2, 3, 1'b1);
        chk("latency_m_valid", m_valid, 1);
        chk("a00", el(m_a, 0, 0), 5);
        chk("a21", el(m_a, 2, 1), 7);
        chk("a11", el(m_a, 1, 1), 0);
        chk("b12", el(m_b, 1, 2), 3);
        chk("b00", el(m_b, 0, 0), 0);
        chk("nnz_a_basic", nnz_a, 2);
        chk("nnz_b_basic", nnz_b, 1);
        chk("idx_err_basic", idx_err, 0);

        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("hold_s_ready", s_ready, 0);
            chk("hold_a21", el(m_a, 2, 1), 7);
        end
        release_pair();
        chk("clear_m_valid", m_valid, 0);
        chk("clear_s_ready", s_ready, 0);
        chk("clear_m_a", m_a, 0);
        chk("clear_m_b", m_b, 0);
        chk("clear_nnz_a", nnz_a, 0);
        @(negedge clk);
        chk("load_s_ready", s_ready, 1);

        // Out-of-range row for A.
        send(SEL_A, 3, 0, 9, 1'b0);
        send(SEL_B, 0, 0, 1, 1'b1);
        chk("oor_idx_err", idx_err, 1);
        chk("oor_m_a", m_a, 0);
        chk("oor_nnz_a", nnz_a, 0);
        chk("oor_b00", el(m_b, 0, 0), 1);
        release_pair();

        // Duplicate coordinate.
        send(SEL_A, 1, 1, 200, 1'b0);
        send(SEL_A, 1, 1, 100, 1'b1);
`ifdef SPARSE_COO_ACCUM_EN
        chk("dup_a11", el(m_a, 1, 1), 255);
`else
        chk("dup_a11", el(m_a, 1, 1), 100);
`endif
        chk("dup_nnz_a", nnz_a, 2);
        release_pair();

        // Full interleaved fill with random gaps, then a 3x3 product check.
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                ta[i][j]  = int'($urandom_range(0, 15));
                tbm[i][j] = int'($urandom_range(0, 15));
            end
        for (int k = 0; k < 2 * N * N; k++) begin
            int p;
            p = k / 2;
            if (k % 2 == 0) send(SEL_A, p / N, p % N, ta[p / N][p % N], 1'b0);
            else            send(SEL_B, p / N, p % N, tbm[p / N][p % N], k == 2 * N * N - 1);
            if (k != 2 * N * N - 1) idle(int'($urandom_range(0, 3)));
        end
        chk("full_m_a", m_a, pack(ta));
        chk("full_m_b", m_b, pack(tbm));
        chk("full_nnz_a", nnz_a, 9);
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) begin
                pe = 0;
                pa = 0;
                for (int k = 0; k < N; k++) begin
                    pe += ta[i][k] * tbm[k][j];
                    pa += int'(el(m_a, i, k)) * int'(el(m_b, k, j));
                end
                chk("product", MW'(pa), MW'(pe));
            end
        release_pair();

        // Reset mid-pair discards partial data.
        send(SEL_A, 0, 0, 11, 1'b0);
        send(SEL_B, 2, 2, 12, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk("abort_m_valid", m_valid, 0);
            @(negedge clk);
        end
        send(SEL_A, 0, 1, 4, 1'b1);
        ev = '0;
        ev[elem_lsb(0, 1) +: W] = 8'd4;
        chk("post_abort_m_a", m_a, ev);
        chk("post_abort_m_b", m_b, 0);
        chk("post_abort_nnz_a", nnz_a, 1);
        chk("post_abort_nnz_b", nnz_b, 0);
        release_pair();

        // Empty pair: only an out-of-range last entry.
        send(SEL_B, 0, 3, 5, 1'b1);
        chk("empty_m_valid", m_valid, 1);
        chk("empty_m_a", m_a, 0);
        chk("empty_m_b", m_b, 0);
        chk("empty_nnz_b", nnz_b, 0);
        chk("empty_idx_err", idx_err, 1);
        release_pair();

        // Counter saturation with 16 writes to one position.
        for (int k = 0; k < 16; k++) send(SEL_A, 2, 2, k + 1, k == 15);
        chk("sat_nnz_a", nnz_a, 15);
`ifdef SPARSE_COO_ACCUM_EN
        chk("sat_a22", el(m_a, 2, 2), 136);
`else
        chk("sat_a22", el(m_a, 2, 2), 16);
`endif
        release_pair();
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
